// File: rtl/core_pkg.sv
// Shared core definitions: ALU select codes (the single source shared with the ALU),
// RV32I opcodes, operand-source encodings and the decoded-instruction bundle.
package core_pkg;

    // ALU operation select
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_LT   = 4'd12;
    localparam logic [3:0] ALU_GE   = 4'd13;
    localparam logic [3:0] ALU_LTU  = 4'd14;
    localparam logic [3:0] ALU_GEU  = 4'd15;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Operand source encodings
    localparam logic [1:0] OP1_RS1  = 2'd0;
    localparam logic [1:0] OP1_PC   = 2'd1;
    localparam logic [1:0] OP1_ZERO = 2'd2;
    localparam logic       OP2_RS2  = 1'b0;
    localparam logic       OP2_IMM  = 1'b1;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

    // All-zero value is the reset / NOP state: ADD, rs1 + rs2, no side effects.
    typedef struct packed {
        logic [3:0]  alusel;
        logic [1:0]  op1_sel;
        logic        op2_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } dec_t;

    // Build the sign-extended immediate for a given encoding format.
    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            ImmU:    imm = {instr[31:12], 12'b0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/core_decode_comb.sv
// Combinational RV32I instruction-to-fields decode.
// Optional feature macro: CORE_DECODE_ILLEGAL_EN -- when defined, undecodable encodings
// raise the illegal flag; otherwise they decode as a NOP with the flag held at 0.
module core_decode_comb
    import core_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    imm_fmt_e   fmt;
    dec_t       dec;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Decode opcode/funct fields into ALU select, operand sources and control flags
    always_comb begin
        dec         = '0;
        legal       = 1'b1;
        fmt         = ImmNone;
        dec.rs1     = instr_i[19:15];
        dec.rs2     = instr_i[24:20];
        dec.rd      = instr_i[11:7];
        dec.alusel  = ALU_ADD;
        dec.op1_sel = OP1_RS1;
        dec.op2_sel = OP2_RS2;

        case (opcode)
            OPC_OP: begin
                dec.rf_we = 1'b1;
                case (funct3)
                    3'd0:    dec.alusel = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'd1:    dec.alusel = ALU_SLL;
                    3'd2:    dec.alusel = ALU_SLT;
                    3'd3:    dec.alusel = ALU_SLTU;
                    3'd4:    dec.alusel = ALU_XOR;
                    3'd5:    dec.alusel = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'd6:    dec.alusel = ALU_OR;
                    default: dec.alusel = ALU_AND;
                endcase
                // Only SUB and SRA use the alternate funct7
                if (funct7 == FUNCT7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == FUNCT7_ALT && (funct3 == 3'd0 || funct3 == 3'd5)) begin
                    legal = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end

            OPC_OP_IMM: begin
                fmt         = ImmI;
                dec.op2_sel = OP2_IMM;
                dec.rs2     = '0;
                dec.rf_we   = 1'b1;
                case (funct3)
                    3'd0:    dec.alusel = ALU_ADD;
                    3'd1:    dec.alusel = ALU_SLL;
                    3'd2:    dec.alusel = ALU_SLT;
                    3'd3:    dec.alusel = ALU_SLTU;
                    3'd4:    dec.alusel = ALU_XOR;
                    3'd5:    dec.alusel = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'd6:    dec.alusel = ALU_OR;
                    default: dec.alusel = ALU_AND;
                endcase
                // Shift-immediates carry funct7 in the upper immediate bits
                if (funct3 == 3'd1) begin
                    legal = (funct7 == FUNCT7_BASE);
                end else if (funct3 == 3'd5) begin
                    legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                end
            end

            OPC_LOAD: begin
                fmt          = ImmI;
                dec.op2_sel  = OP2_IMM;
                dec.rs2      = '0;
                dec.rf_we    = 1'b1;
                dec.mem_re   = 1'b1;
                dec.mem_size = funct3;
                legal        = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end

            OPC_STORE: begin
                fmt          = ImmS;
                dec.op2_sel  = OP2_IMM;
                dec.rd       = '0;
                dec.mem_we   = 1'b1;
                dec.mem_size = funct3;
                legal        = (funct3 <= 3'd2);
            end

            OPC_BRANCH: begin
                fmt        = ImmB;
                dec.rd     = '0;
                dec.branch = 1'b1;
                case (funct3)
                    3'd0:    dec.alusel = ALU_EQ;
                    3'd1:    dec.alusel = ALU_NE;
                    3'd4:    dec.alusel = ALU_LT;
                    3'd5:    dec.alusel = ALU_GE;
                    3'd6:    dec.alusel = ALU_LTU;
                    3'd7:    dec.alusel = ALU_GEU;
                    default: legal = 1'b0;
                endcase
            end

            OPC_JAL: begin
                fmt         = ImmJ;
                dec.op1_sel = OP1_PC;
                dec.op2_sel = OP2_IMM;
                dec.rs1     = '0;
                dec.rs2     = '0;
                dec.rf_we   = 1'b1;
                dec.jal     = 1'b1;
            end

            OPC_JALR: begin
                fmt         = ImmI;
                dec.op2_sel = OP2_IMM;
                dec.rs2     = '0;
                dec.rf_we   = 1'b1;
                dec.jalr    = 1'b1;
                legal       = (funct3 == 3'd0);
            end

            OPC_LUI: begin
                fmt         = ImmU;
                dec.op1_sel = OP1_ZERO;
                dec.op2_sel = OP2_IMM;
                dec.rs1     = '0;
                dec.rs2     = '0;
                dec.rf_we   = 1'b1;
            end

            OPC_AUIPC: begin
                fmt         = ImmU;
                dec.op1_sel = OP1_PC;
                dec.op2_sel = OP2_IMM;
                dec.rs1     = '0;
                dec.rs2     = '0;
                dec.rf_we   = 1'b1;
            end

            // Fences and system instructions have no architectural effect here
            OPC_FENCE, OPC_SYSTEM: begin
                fmt         = ImmI;
                dec.op2_sel = OP2_IMM;
                dec.rs2     = '0;
                dec.rf_we   = 1'b0;
            end

            default: legal = 1'b0;
        endcase

        dec.imm = gen_imm(instr_i, fmt);

        // x0 is never written
        if (dec.rd == 5'd0) begin
            dec.rf_we = 1'b0;
        end

        // Undecodable encodings collapse to the NOP bundle
        if (!legal) begin
            dec = '0;
`ifdef CORE_DECODE_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
        end
    end

    assign dec_o = dec;

endmodule

// File: rtl/core_decode.sv
// RV32I decode stage: valid/ready handshake and output pipeline register around
// core_decode_comb. Optional feature macro: CORE_DECODE_ILLEGAL_EN (illegal-flag reporting).
module core_decode
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_alusel,
    output logic [1:0]  out_op1_sel,
    output logic        out_op2_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_rf_we,
    output logic        out_mem_re,
    output logic        out_mem_we,
    output logic [2:0]  out_mem_size,
    output logic        out_branch,
    output logic        out_jal,
    output logic        out_jalr,
    output logic        out_illegal
);

    dec_t        dec_comb;
    dec_t        dec_d, dec_q;
    logic [31:0] pc_d, pc_q;
    logic        valid_d, valid_q;
    logic        accept;

    core_decode_comb u_comb (
        .instr_i (in_instr),
        .dec_o   (dec_comb)
    );

    // Ready whenever the output slot is empty or being drained; never during reset or flush
    always_comb begin
        in_ready = !rst && !flush && (!valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Next-state: flush kills the slot, accept loads it, a drain without refill empties it
    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec_comb;
            pc_d    = in_pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous reset to the all-zero NOP bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            pc_q    <= pc_d;
        end
    end

    // Drive the registered fields onto the execute-stage interface
    always_comb begin
        out_valid    = valid_q;
        out_pc       = pc_q;
        out_alusel   = dec_q.alusel;
        out_op1_sel  = dec_q.op1_sel;
        out_op2_sel  = dec_q.op2_sel;
        out_imm      = dec_q.imm;
        out_rs1      = dec_q.rs1;
        out_rs2      = dec_q.rs2;
        out_rd       = dec_q.rd;
        out_rf_we    = dec_q.rf_we;
        out_mem_re   = dec_q.mem_re;
        out_mem_we   = dec_q.mem_we;
        out_mem_size = dec_q.mem_size;
        out_branch   = dec_q.branch;
        out_jal      = dec_q.jal;
        out_jalr     = dec_q.jalr;
`ifdef CORE_DECODE_ILLEGAL_EN
        out_illegal  = dec_q.illegal;
`else
        out_illegal  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_core_decode.sv
// Directed bench for core_decode: reset, per-opcode decode, stall, flush,
// reset during stall and back-to-back streaming.
module tb_core_decode;

    typedef struct packed {
        logic [3:0]  alusel;
        logic [1:0]  op1;
        logic        op2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  size;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
    } fields_t;

    typedef struct packed {
        logic [31:0] instr;
        fields_t     exp;
    } vec_t;

`ifdef CORE_DECODE_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h407302B3;
    localparam logic [31:0] I_LUI = 32'h123450B7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_alusel;
    logic [1:0]  out_op1_sel;
    logic        out_op2_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rf_we;
    logic        out_mem_re;
    logic        out_mem_we;
    logic [2:0]  out_mem_size;
    logic        out_branch;
    logic        out_jal;
    logic        out_jalr;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_decode dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_alusel   (out_alusel),
        .out_op1_sel  (out_op1_sel),
        .out_op2_sel  (out_op2_sel),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_rf_we    (out_rf_we),
        .out_mem_re   (out_mem_re),
        .out_mem_we   (out_mem_we),
        .out_mem_size (out_mem_size),
        .out_branch   (out_branch),
        .out_jal      (out_jal),
        .out_jalr     (out_jalr),
        .out_illegal  (out_illegal)
    );

    function automatic fields_t observed();
        return {out_alusel, out_op1_sel, out_op2_sel, out_imm, out_rs1, out_rs2, out_rd,
                out_rf_we, out_mem_re, out_mem_we, out_mem_size, out_branch, out_jal,
                out_jalr, out_illegal};
    endfunction

    function automatic fields_t mk(input logic [3:0] alu, input logic [1:0] op1,
                                   input logic op2, input logic [31:0] imm,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd, input logic we, input logic re,
                                   input logic mwe, input logic [2:0] size, input logic br,
                                   input logic jal, input logic jalr, input logic ill);
        return {alu, op1, op2, imm, rs1, rs2, rd, we, re, mwe, size, br, jal, jalr, ill};
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADD;
        in_pc     = 32'h40;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (observed() !== fields_t'(0) || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h pc %h want 0", observed(), out_pc);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_decode();
        vec_t vecs[15];
        vecs[0]  = '{I_ADD,        mk(0, 0, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{I_SUB,        mk(1, 0, 0, 32'h0, 6, 7, 5, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{I_LUI,        mk(0, 2, 1, 32'h12345000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{32'hFE20FEE3, mk(15, 0, 0, 32'hFFFFFFFC, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[4]  = '{32'hFFF00093, mk(0, 0, 1, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{32'h4030D113, mk(7, 0, 1, 32'h00000403, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{32'h0020A423, mk(0, 0, 1, 32'h8, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 0)};
        vecs[7]  = '{32'hFFC0A283, mk(0, 0, 1, 32'hFFFFFFFC, 1, 0, 5, 1, 1, 0, 2, 0, 0, 0, 0)};
        vecs[8]  = '{32'h008000EF, mk(0, 1, 1, 32'h8, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
        vecs[9]  = '{32'h000100E7, mk(0, 0, 1, 32'h0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0)};
        vecs[10] = '{32'h00001117, mk(0, 1, 1, 32'h1000, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{32'h00208033, mk(0, 0, 0, 32'h0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[12] = '{32'h0000000F, mk(0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[13] = '{32'hFFFFFFFF, mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ILL)};
        vecs[14] = '{32'h022081B3, mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ILL)};
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h100 + 32'(i * 4);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL decode_ready[%0d]: got %b want 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(i * 4)) begin
                errors++;
                $display("FAIL decode_valid[%0d]: got v=%b pc=%h want v=1 pc=%h", i, out_valid,
                         out_pc, 32'h100 + 32'(i * 4));
            end
            checks++;
            if (observed() !== vecs[i].exp) begin
                errors++;
                $display("FAIL decode_fields[%0d] instr %h: got %h want %h", i, vecs[i].instr,
                         observed(), vecs[i].exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = I_ADD;
        in_pc    = 32'h500;
        @(negedge clk);
        in_instr = I_SUB;
        in_pc    = 32'h504;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h500 || out_alusel !== 4'd0 || out_rd !== 5'd3)
        begin
            errors++;
            $display("FAIL stall_hold: got v=%b pc=%h alu=%0d rd=%0d want v=1 pc=500 alu=0 rd=3",
                     out_valid, out_pc, out_alusel, out_rd);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h504 || out_alusel !== 4'd1 || out_rd !== 5'd5)
        begin
            errors++;
            $display("FAIL stall_second: got v=%b pc=%h alu=%0d rd=%0d want v=1 pc=504 alu=1 rd=5",
                     out_valid, out_pc, out_alusel, out_rd);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = I_LUI;
        in_pc    = 32'h600;
        @(negedge clk);
        in_instr = I_SUB;
        in_pc    = 32'h604;
        flush    = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h600) begin
            errors++;
            $display("FAIL flush_kill: got v=%b pc=%h want v=0 pc=600", out_valid, out_pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'hFE20FEE3;
        in_pc    = 32'h700;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || observed() !== fields_t'(0) || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_stall_clear: got v=%b f=%h pc=%h want all 0", out_valid,
                     observed(), out_pc);
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = (i % 2 == 0) ? I_ADD : I_SUB;
            in_pc    = 32'h800 + 32'(i * 4);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h800 + 32'((i - 1) * 4)) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v=%b pc=%h want v=1 pc=%h", i, out_valid,
                             out_pc, 32'h800 + 32'((i - 1) * 4));
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h80C || out_alusel !== 4'd1) begin
            errors++;
            $display("FAIL b2b_last: got v=%b pc=%h alu=%0d want v=1 pc=80c alu=1", out_valid,
                     out_pc, out_alusel);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got %b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
